// File: rtl/uart_cmd_decoder.sv
// Assembles 5-byte command frames (SYNC, ADDR, DATA_H, DATA_L, SUM) from the UART
// byte stream and turns each valid frame into a single-cycle register write.
module uart_cmd_decoder #(
    parameter logic [7:0]        SYNC_BYTE = 8'hA5,
    parameter int unsigned       TO_WID    = 16,
    parameter logic [TO_WID-1:0] TO_CNT    = 16'd50000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_data,
    input  logic        i_dataen,
    output logic        o_wr_en,
    output logic [7:0]  o_wr_addr,
    output logic [15:0] o_wr_data,
    output logic        o_err,
    output logic [7:0]  o_err_cnt,
    output logic        o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATH,
        S_DATL,
        S_SUM
    } state_t;

    state_t              r_state;
    logic [TO_WID-1:0]   r_to_cnt;
    logic [7:0]          r_addr;
    logic [7:0]          r_dath;
    logic [7:0]          r_datl;

    logic [7:0]          w_sum;
    logic                w_sum_byte;
    logic                w_timeout;
    logic                w_wr_set;
    logic                w_err_set;

    // Checksum wraps in 8 bits; carries are intentionally dropped.
    assign w_sum      = r_addr + r_dath + r_datl;
    assign w_sum_byte = (r_state == S_SUM) && i_dataen;
    // A byte arriving on the limit cycle takes priority over the timeout.
    assign w_timeout  = (r_state != S_IDLE) && !i_dataen && (r_to_cnt == TO_CNT);
    assign w_wr_set   = w_sum_byte && (i_data == w_sum);
    assign w_err_set  = (w_sum_byte && (i_data != w_sum)) || w_timeout;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_to_cnt  <= '0;
            r_addr    <= '0;
            r_dath    <= '0;
            r_datl    <= '0;
            o_wr_en   <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
            o_err     <= 1'b0;
            o_err_cnt <= '0;
            o_busy    <= 1'b0;
        end else begin
            o_wr_en <= w_wr_set;
            o_err   <= w_err_set;

            if ((r_state == S_IDLE) || i_dataen || w_timeout) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + TO_WID'(1);
            end

            if (w_wr_set) begin
                o_wr_addr <= r_addr;
                o_wr_data <= {r_dath, r_datl};
            end

            if (w_err_set && (o_err_cnt != 8'hFF)) begin
                o_err_cnt <= o_err_cnt + 8'd1;
            end

            if (w_timeout) begin
                r_state <= S_IDLE;
                o_busy  <= 1'b0;
            end else if (i_dataen) begin
                case (r_state)
                    S_IDLE: begin
                        if (i_data == SYNC_BYTE) begin
                            r_state <= S_ADDR;
                            o_busy  <= 1'b1;
                        end
                    end
                    S_ADDR: begin
                        r_addr  <= i_data;
                        r_state <= S_DATH;
                    end
                    S_DATH: begin
                        r_dath  <= i_data;
                        r_state <= S_DATL;
                    end
                    S_DATL: begin
                        r_datl  <= i_data;
                        r_state <= S_SUM;
                    end
                    S_SUM: begin
                        r_state <= S_IDLE;
                        o_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        o_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder with a shortened inter-byte timeout.
module tb_uart_cmd_decoder;

    localparam int unsigned TO_WID = 16;

    logic        i_clk;
    logic        i_rst_n;
    logic [7:0]  i_data;
    logic        i_dataen;
    logic        o_wr_en;
    logic [7:0]  o_wr_addr;
    logic [15:0] o_wr_data;
    logic        o_err;
    logic [7:0]  o_err_cnt;
    logic        o_busy;

    int n_checks;
    int n_fail;
    int n_wr;
    int n_errp;
    int n_both;
    int wr0;
    int err0;

    uart_cmd_decoder #(
        .SYNC_BYTE (8'hA5),
        .TO_WID    (TO_WID),
        .TO_CNT    (16'd100)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_data    (i_data),
        .i_dataen  (i_dataen),
        .o_wr_en   (o_wr_en),
        .o_wr_addr (o_wr_addr),
        .o_wr_data (o_wr_data),
        .o_err     (o_err),
        .o_err_cnt (o_err_cnt),
        .o_busy    (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge i_clk) begin
        if (o_wr_en) n_wr++;
        if (o_err) n_errp++;
        if (o_wr_en && o_err) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; byte is sampled on the next edge, returns at that edge+1.
    task automatic send_byte(input logic [7:0] b);
        i_data   = b;
        i_dataen = 1'b1;
        @(posedge i_clk);
        #1;
        i_dataen = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] h,
                              input logic [7:0] l, input logic [7:0] s, input int gap);
        send_byte(8'hA5); idle(gap);
        send_byte(a);     idle(gap);
        send_byte(h);     idle(gap);
        send_byte(l);     idle(gap);
        send_byte(s);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        n_checks = 0; n_fail = 0; n_wr = 0; n_errp = 0; n_both = 0;
        i_rst_n  = 1'b0;
        i_data   = 8'h00;
        i_dataen = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        idle(1);

        check("rst_wr_en",   32'(o_wr_en),   32'h0);
        check("rst_wr_addr", 32'(o_wr_addr), 32'h0);
        check("rst_wr_data", 32'(o_wr_data), 32'h0);
        check("rst_err",     32'(o_err),     32'h0);
        check("rst_err_cnt", 32'(o_err_cnt), 32'h0);
        check("rst_busy",    32'(o_busy),    32'h0);

        // Good frame, 100-clock gaps (each next byte lands on the limit cycle).
        send_frame(8'h12, 8'h34, 8'h56, 8'h9C, 100);
        check("good_wr_en",   32'(o_wr_en),   32'h1);
        check("good_err",     32'(o_err),     32'h0);
        check("good_addr",    32'(o_wr_addr), 32'h12);
        check("good_data",    32'(o_wr_data), 32'h3456);
        check("good_busy",    32'(o_busy),    32'h0);
        idle(1);
        check("good_wr_1cyc", 32'(o_wr_en),   32'h0);
        check("good_nwr",     32'(n_wr),      32'd1);
        check("good_nerr",    32'(n_errp),    32'd0);

        // Bad checksum: 77+88+99 = 0x98, send 0x99.
        send_frame(8'h77, 8'h88, 8'h99, 8'h99, 0);
        check("bad_err",     32'(o_err),     32'h1);
        check("bad_wr_en",   32'(o_wr_en),   32'h0);
        check("bad_err_cnt", 32'(o_err_cnt), 32'd1);
        check("bad_addr",    32'(o_wr_addr), 32'h12);
        check("bad_data",    32'(o_wr_data), 32'h3456);
        idle(1);
        check("bad_err_1cyc", 32'(o_err), 32'h0);

        // Wrap-around checksum with SYNC value as data.
        send_frame(8'hFF, 8'hA5, 8'hFF, 8'hA3, 0);
        check("wrap_wr_en", 32'(o_wr_en),   32'h1);
        check("wrap_addr",  32'(o_wr_addr), 32'hFF);
        check("wrap_data",  32'(o_wr_data), 32'hA5FF);
        check("wrap_err",   32'(o_err),     32'h0);
        idle(2);

        // Timeout: o_err rises on the 101st edge after the ADDR byte.
        send_byte(8'hA5);
        send_byte(8'h12);
        idle(99);
        check("to_early_err",  32'(o_err),  32'h0);
        check("to_early_busy", 32'(o_busy), 32'h1);
        idle(1);
        check("to_edge100_err", 32'(o_err), 32'h0);
        idle(1);
        check("to_err",     32'(o_err),     32'h1);
        check("to_busy",    32'(o_busy),    32'h0);
        check("to_err_cnt", 32'(o_err_cnt), 32'd2);
        idle(1);
        check("to_err_1cyc", 32'(o_err), 32'h0);
        send_frame(8'h01, 8'h02, 8'h03, 8'h06, 0);
        check("to_after_wr",   32'(o_wr_en),   32'h1);
        check("to_after_addr", 32'(o_wr_addr), 32'h01);
        check("to_after_data", 32'(o_wr_data), 32'h0203);
        idle(1);

        // Boundary: byte on the exact limit cycle continues the frame.
        send_byte(8'hA5);
        send_byte(8'h12);
        idle(100);
        send_byte(8'h34);
        check("bnd_err",  32'(o_err),  32'h0);
        check("bnd_busy", 32'(o_busy), 32'h1);
        send_byte(8'h56);
        send_byte(8'h9C);
        check("bnd_wr_en", 32'(o_wr_en), 32'h1);
        idle(1);

        // Noise in IDLE is discarded silently.
        err0 = n_errp;
        send_byte(8'h00);
        send_byte(8'h7F);
        send_byte(8'h55);
        idle(2);
        check("noise_busy",    32'(o_busy),    32'h0);
        check("noise_nerr",    32'(n_errp),    32'(err0));
        check("noise_err_cnt", 32'(o_err_cnt), 32'd2);

        // Saturation after 300 bad frames.
        err0 = n_errp;
        for (int i = 0; i < 300; i++) begin
            send_frame(8'h00, 8'h00, 8'h00, 8'h01, 0);
        end
        idle(1);
        check("sat_err_cnt", 32'(o_err_cnt), 32'hFF);
        check("sat_npulse",  32'(n_errp),    32'(err0 + 300));

        // Asynchronous reset mid-frame.
        send_byte(8'hA5);
        send_byte(8'h12);
        send_byte(8'h34);
        i_rst_n = 1'b0;
        #2;
        check("arst_busy",    32'(o_busy),    32'h0);
        check("arst_err_cnt", 32'(o_err_cnt), 32'h0);
        check("arst_addr",    32'(o_wr_addr), 32'h0);
        check("arst_data",    32'(o_wr_data), 32'h0);
        check("arst_wr_en",   32'(o_wr_en),   32'h0);
        check("arst_err",     32'(o_err),     32'h0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        wr0  = n_wr;
        err0 = n_errp;
        send_byte(8'h56);
        send_byte(8'h9C);
        idle(2);
        check("post_rst_nwr",  32'(n_wr),      32'(wr0));
        check("post_rst_nerr", 32'(n_errp),    32'(err0));
        check("post_rst_busy", 32'(o_busy),    32'h0);
        check("post_rst_cnt",  32'(o_err_cnt), 32'h0);
        check("never_both",    32'(n_both),    32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Consumes the received-byte stream (8-bit data plus 1-cycle valid pulse) from the UART receiver.
- Assembles fixed 5-byte command frames: SYNC, ADDR, DATA_H, DATA_L, SUM.
- Validates the checksum and an inter-byte timeout.
- On success, issues a single-cycle register write (8-bit address, 16-bit data) to the pattern-generator register bank. Framing errors are flagged and counted.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TO_WID, 16, width of the inter-byte timeout counter.
- TO_CNT, 16'd50000, maximum idle clocks allowed between bytes inside a frame.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_data  input  8  received byte; valid only when i_dataen=1.
- i_dataen  input  1  1-cycle pulse, byte valid.
- o_wr_en  output  1  1-cycle write strobe.
- o_wr_addr  output  8  write address; held between strobes.
- o_wr_data  output  16  write data {DATA_H, DATA_L}; held between strobes.
- o_err  output  1  1-cycle pulse on checksum error or timeout.
- o_err_cnt  output  8  saturating error count.
- o_busy  output  1  1 while a frame is in progress (state != IDLE).

Behaviour:
- Reset values: o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_err=0, o_err_cnt=0, o_busy=0, state=IDLE, timeout counter=0, internal shadow regs=0.
- FSM states: IDLE, ADDR, DATH, DATL, SUM. State advances only on cycles with i_dataen=1.
- IDLE:
  - i_dataen with i_data==SYNC_BYTE -> ADDR.
  - Any other byte is silently discarded: no o_err, no count.
- ADDR: capture byte into addr shadow -> DATH.
- DATH: capture into data-high shadow -> DATL.
- DATL: capture into data-low shadow -> SUM.
- A SYNC_BYTE value received in ADDR/DATH/DATL/SUM is treated as ordinary data. There is no resynchronisation.
- Checksum: SUM = (ADDR + DATA_H + DATA_L) mod 256, computed in 8 bits with carries discarded.
- SUM state, on i_dataen, always -> IDLE.
  - Match: o_wr_en=1 on the next cycle. o_wr_addr and o_wr_data update on that same edge.
  - Mismatch: o_err=1 on the next cycle. o_wr_addr and o_wr_data are unchanged.
- Latency: exactly 1 clock from the SUM-byte i_dataen cycle to o_wr_en or o_err.
- o_wr_en and o_err are never asserted together and are never longer than 1 cycle.
- Timeout counter:
  - Cleared to 0 in IDLE and on every i_dataen.
  - Otherwise increments by 1 each clock while state != IDLE.
  - When the counter == TO_CNT and i_dataen=0 in that cycle: state -> IDLE, o_err=1 on the next cycle, counter cleared.
  - If i_dataen coincides with counter == TO_CNT, the byte wins: it is processed normally and no timeout occurs.
- Shortest accepted frame: 5 back-to-back bytes. i_dataen may assert on consecutive cycles; no minimum gap is required.
- o_err_cnt: increments by 1 on every o_err pulse and saturates at 8'hFF (no wrap).
- o_busy is a registered decode of state != IDLE. It goes high the cycle after SYNC is accepted and low the cycle after the SUM byte or a timeout.
- Asynchronous reset mid-frame: the partial frame is discarded immediately, all outputs return to reset values, and no o_wr_en or o_err is generated.

Test Plan:
- Good frame: bytes A5 12 34 56 9C, 100-clock gaps -> one o_wr_en pulse 1 clk after the 9C byte; o_wr_addr=8'h12, o_wr_data=16'h3456; o_err never high.
- Bad checksum: A5 12 34 56 9D -> o_err pulse 1 clk after the last byte; o_err_cnt=1; o_wr_addr/o_wr_data keep previous values; no o_wr_en.
- Wrap-around sum and in-frame sync: A5 FF A5 FF A3 (FF+A5+FF=2A3, mod 256 = A3), bytes back-to-back -> o_wr_en; o_wr_addr=FF, o_wr_data=16'hA5FF.
- Timeout (TO_CNT=100): A5 12, then silence -> o_err exactly 101 clocks after the 12 byte; o_busy drops; a following complete good frame is accepted. Boundary case: send the next byte on the exact TO_CNT cycle -> no error, frame continues.
- Noise and saturation: send 00 7F 55 in IDLE -> no o_err, o_busy stays 0. Then send 300 bad-checksum frames -> o_err_cnt stops at 8'hFF.
- Reset mid-frame: A5 12 34, pulse i_rst_n low -> all outputs 0; then send 56 9C -> ignored (no o_wr_en, no o_err).
